// File: rtl/v_mem_sched.sv
// v_mem_sched: controller for one single-port N x W table RAM.
// On reset or flush it zero-fills every word. Otherwise it shares the RAM port among R
// requesters by round-robin arbitration and returns read data tagged with the requester index.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_flush_req       request a zero-fill of the whole table
//   o_busy_r          sweep or flush in progress; no requests accepted
//   i_req_vld/wen     per-requester valid and command type (1 = write)
//   i_req_addr/wdata  per-requester address and write data, packed by requester index
//   o_req_rdy         one-hot grant (combinational)
//   o_rsp_*_r         read response: valid, owning requester, data
//   o_mem_*_r         registered RAM command
//   i_mem_rdata       RAM read data, one cycle after a read command
module v_mem_sched #(
  parameter int unsigned N  = 64,
  parameter int unsigned W  = 32,
  parameter int unsigned R  = 2,
  localparam int unsigned AW = $clog2(N),
  localparam int unsigned IW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush_req,
  output logic            o_busy_r,
  input  logic [R-1:0]    i_req_vld,
  input  logic [R-1:0]    i_req_wen,
  input  logic [R*AW-1:0] i_req_addr,
  input  logic [R*W-1:0]  i_req_wdata,
  output logic [R-1:0]    o_req_rdy,
  output logic            o_rsp_vld_r,
  output logic [IW-1:0]   o_rsp_id_r,
  output logic [W-1:0]    o_rsp_rdata_r,
  output logic            o_mem_en_r,
  output logic            o_mem_wen_r,
  output logic [AW-1:0]   o_mem_addr_r,
  output logic [W-1:0]    o_mem_wdata_r,
  input  logic [W-1:0]    i_mem_rdata
);

  typedef enum logic [1:0] {StInit, StRun, StDrain} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(N - 1);
  localparam logic [IW:0]   NumReq   = (IW+1)'(R);
  localparam logic [IW-1:0] LastReq  = IW'(R - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic [IW-1:0] ptr_q;
  // Two-stage read tracker: stage 1 = command on the RAM port, stage 2 = data on i_mem_rdata.
  logic          rd1_vld_q, rd2_vld_q;
  logic [IW-1:0] rd1_id_q, rd2_id_q;

  logic [R-1:0]  grant;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic [IW:0]   cand;

  // Round-robin search starting at the pointer, wrapping from R-1 to 0.
  // A flush request blocks all grants in that cycle.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (state_q == StRun && !i_flush_req) begin
      for (int unsigned i = 0; i < R; i++) begin
        cand = {1'b0, ptr_q} + (IW+1)'(i);
        if (cand >= NumReq) cand = cand - NumReq;
        if (!gnt_any && i_req_vld[cand[IW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[IW-1:0];
        end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
    end
  end

  assign o_req_rdy = grant;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:  if (cnt_q == LastAddr) state_d = StRun;
      StRun:   if (i_flush_req) state_d = StDrain;
      StDrain: if (!rd1_vld_q && !rd2_vld_q) state_d = StInit;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      cnt_q         <= '0;
      ptr_q         <= '0;
      o_busy_r      <= 1'b1;
      o_mem_en_r    <= 1'b0;
      o_mem_wen_r   <= 1'b0;
      o_mem_addr_r  <= '0;
      o_mem_wdata_r <= '0;
      rd1_vld_q     <= 1'b0;
      rd1_id_q      <= '0;
      rd2_vld_q     <= 1'b0;
      rd2_id_q      <= '0;
      o_rsp_vld_r   <= 1'b0;
      o_rsp_id_r    <= '0;
      o_rsp_rdata_r <= '0;
    end else begin
      state_q  <= state_d;
      o_busy_r <= (state_d != StRun);

      o_mem_en_r    <= 1'b0;
      o_mem_wen_r   <= 1'b0;
      o_mem_addr_r  <= '0;
      o_mem_wdata_r <= '0;

      case (state_q)
        StInit: begin
          o_mem_en_r    <= 1'b1;
          o_mem_wen_r   <= 1'b1;
          o_mem_addr_r  <= cnt_q;
          o_mem_wdata_r <= '0;
          cnt_q         <= (cnt_q == LastAddr) ? '0 : cnt_q + 1'b1;
        end
        StRun: begin
          if (gnt_any) begin
            o_mem_en_r    <= 1'b1;
            o_mem_wen_r   <= i_req_wen[gnt_idx];
            o_mem_addr_r  <= i_req_addr[gnt_idx*AW +: AW];
            o_mem_wdata_r <= i_req_wdata[gnt_idx*W +: W];
            ptr_q         <= (gnt_idx == LastReq) ? '0 : gnt_idx + 1'b1;
          end
        end
        default: cnt_q <= '0;  // next sweep always starts at address 0
      endcase

      rd1_vld_q <= gnt_any && !i_req_wen[gnt_idx];
      rd1_id_q  <= gnt_idx;
      rd2_vld_q <= rd1_vld_q;
      rd2_id_q  <= rd1_id_q;

      o_rsp_vld_r <= rd2_vld_q;
      if (rd2_vld_q) begin
        o_rsp_id_r    <= rd2_id_q;
        o_rsp_rdata_r <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_v_mem_sched.sv
// Self-checking bench for v_mem_sched (N=8, W=32, R=2) with a behavioural RAM and a
// queue-based reference model of arbitration, RAM contents and response timing.
module tb_v_mem_sched;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 32;
  localparam int unsigned R  = 2;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned IW = $clog2(R);

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } exp_rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush_req = 1'b0;
  logic [R-1:0]    req_vld = '0;
  logic [R-1:0]    req_wen = '0;
  logic [R*AW-1:0] req_addr = '0;
  logic [R*W-1:0]  req_wdata = '0;
  logic            busy;
  logic [R-1:0]    rdy;
  logic            rsp_vld;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_rdata;
  logic            mem_en;
  logic            mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [W-1:0]    mem_wdata;
  logic [W-1:0]    mem_rdata = '0;

  logic [W-1:0]    ram [N];
  logic            poke_en = 1'b0;
  logic [AW-1:0]   poke_addr = '0;
  logic [W-1:0]    poke_data = '0;

  logic [W-1:0]    ref_mem [N];
  int              ref_ptr = 0;
  int              vectors = 0;
  int              miscompares = 0;
  int              cyc = 0;

  v_mem_sched #(.N(N), .W(W), .R(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush_req  (flush_req),
    .o_busy_r     (busy),
    .i_req_vld    (req_vld),
    .i_req_wen    (req_wen),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_req_rdy    (rdy),
    .o_rsp_vld_r  (rsp_vld),
    .o_rsp_id_r   (rsp_id),
    .o_rsp_rdata_r(rsp_rdata),
    .o_mem_en_r   (mem_en),
    .o_mem_wen_r  (mem_wen),
    .o_mem_addr_r (mem_addr),
    .o_mem_wdata_r(mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with one-cycle read latency; poke lets the bench preload a word.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_en) begin
      if (mem_wen) ram[mem_addr] <= mem_wdata;
      else         mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference arbiter: first valid requester at or after ptr, wrapping.
  function automatic int rr_pick(logic [R-1:0] vld, int ptr);
    for (int i = 0; i < R; i++) if (vld[(ptr + i) % R]) return (ptr + i) % R;
    return -1;
  endfunction

  task automatic poke(int a, logic [W-1:0] d);
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = d; ref_mem[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Waits for the sweep to start, then expects N back-to-back zero writes to 0..N-1.
  task automatic check_sweep(string tag);
    int   waited = 0;
    logic exp_busy;
    @(negedge clk);
    while (mem_en !== 1'b1 && waited < 40) begin
      vectors++;
      if (busy !== 1'b1 || rdy !== '0)
        $display("FAIL %s_wait: busy=%0b rdy=%b want busy=1 rdy=0", tag, busy, rdy);
      if (busy !== 1'b1 || rdy !== '0) miscompares++;
      waited++;
      @(negedge clk);
    end
    if (waited >= 40) begin
      vectors++; miscompares++;
      $display("FAIL %s_start: sweep never started, mem_en=%0b want 1", tag, mem_en);
    end else begin
      for (int a = 0; a < N; a++) begin
        vectors++;
        if ({mem_en, mem_wen, mem_addr, mem_wdata} !== {1'b1, 1'b1, AW'(a), {W{1'b0}}}) begin
          miscompares++;
          $display("FAIL %s_write%0d: en=%0b wen=%0b addr=%0d wdata=%h want en=1 wen=1 addr=%0d wdata=0",
                   tag, a, mem_en, mem_wen, mem_addr, mem_wdata, a);
        end
        exp_busy = (a == N - 1) ? 1'b0 : 1'b1;
        vectors++;
        if (busy !== exp_busy) begin
          miscompares++;
          $display("FAIL %s_busy%0d: busy=%0b want %0b", tag, a, busy, exp_busy);
        end
        @(negedge clk);
      end
      vectors++;
      if (mem_en !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_extra: mem_en=%0b addr=%0d want no further write", tag, mem_en, mem_addr);
      end
    end
    for (int a = 0; a < N; a++) ref_mem[a] = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    req_vld = '1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy: busy=%0b want 1", busy);
    end
    vectors++;
    if ({mem_en, mem_wen, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mem: en=%0b wen=%0b addr=%0d wdata=%h want all 0",
               mem_en, mem_wen, mem_addr, mem_wdata);
    end
    vectors++;
    if ({rsp_vld, rsp_id, rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: vld=%0b id=%0d data=%h want all 0", rsp_vld, rsp_id, rsp_rdata);
    end
    vectors++;
    if (rdy !== '0) begin
      miscompares++; $display("FAIL reset_rdy: rdy=%b want 0", rdy);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    req_vld = '0;
    check_sweep("reset_sweep");
    ref_ptr = 0;
  endtask

  task automatic test_single_read();
    poke(5, 32'hDEAD_BEEF);
    req_vld = 2'b10; req_wen = '0; req_addr[AW +: AW] = AW'(5);
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b10) begin
      miscompares++; $display("FAIL single_rdy: rdy=%b want 10", rdy);
    end
    @(posedge clk); #1;
    req_vld = '0; ref_ptr = 0;
    @(negedge clk);
    vectors++;
    if ({mem_en, mem_wen, mem_addr} !== {1'b1, 1'b0, AW'(5)}) begin
      miscompares++;
      $display("FAIL single_cmd: en=%0b wen=%0b addr=%0d want en=1 wen=0 addr=5",
               mem_en, mem_wen, mem_addr);
    end
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b0) begin
      miscompares++; $display("FAIL single_early: rsp_vld=%0b want 0", rsp_vld);
    end
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_id !== IW'(1) || rsp_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_rsp: vld=%0b id=%0d data=%h want vld=1 id=1 data=deadbeef",
               rsp_vld, rsp_id, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    req_vld = 2'b01; req_wen = 2'b01;
    req_addr[0 +: AW] = AW'(3); req_wdata[0 +: W] = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b01) begin
      miscompares++; $display("FAIL wr_rdy: rdy=%b want 01", rdy);
    end
    @(posedge clk); #1;
    req_wen = '0; ref_mem[3] = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b01) begin
      miscompares++; $display("FAIL rd_rdy: rdy=%b want 01", rdy);
    end
    vectors++;
    if ({mem_en, mem_wen, mem_addr, mem_wdata} !== {1'b1, 1'b1, AW'(3), 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL wr_cmd: en=%0b wen=%0b addr=%0d wdata=%h want en=1 wen=1 addr=3 wdata=12345678",
               mem_en, mem_wen, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    req_vld = '0; ref_ptr = 1;
    @(negedge clk);
    vectors++;
    if ({mem_en, mem_wen, mem_addr} !== {1'b1, 1'b0, AW'(3)}) begin
      miscompares++;
      $display("FAIL rd_cmd: en=%0b wen=%0b addr=%0d want en=1 wen=0 addr=3",
               mem_en, mem_wen, mem_addr);
    end
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b0) begin
      miscompares++; $display("FAIL wr_norsp: rsp_vld=%0b want 0", rsp_vld);
    end
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_id !== IW'(0) || rsp_rdata !== ref_mem[3]) begin
      miscompares++;
      $display("FAIL wr_rd_rsp: vld=%0b id=%0d data=%h want vld=1 id=0 data=%h",
               rsp_vld, rsp_id, rsp_rdata, ref_mem[3]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    exp_rsp_t     q[$];
    int           g;
    logic [R-1:0] exp_rdy;
    req_vld = 2'b11; req_wen = '0;
    req_addr[0 +: AW] = AW'(0); req_addr[AW +: AW] = AW'(1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g = rr_pick(req_vld, ref_ptr);
      exp_rdy = (g >= 0) ? (R'(1) << g) : '0;
      vectors++;
      if (rdy !== exp_rdy) begin
        miscompares++; $display("FAIL rr_grant%0d: rdy=%b want %b", i, rdy, exp_rdy);
      end
      if (g >= 0) begin
        q.push_back('{due: cyc + 3, id: g, data: ref_mem[g]});
        ref_ptr = (g + 1) % R;
      end
      vectors++;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (rsp_vld !== 1'b1 || rsp_id !== IW'(q[0].id) || rsp_rdata !== q[0].data) begin
          miscompares++;
          $display("FAIL rr_rsp%0d: vld=%0b id=%0d data=%h want vld=1 id=%0d data=%h",
                   i, rsp_vld, rsp_id, rsp_rdata, q[0].id, q[0].data);
        end
        void'(q.pop_front());
      end else if (rsp_vld !== 1'b0) begin
        miscompares++; $display("FAIL rr_idle%0d: rsp_vld=%0b want 0", i, rsp_vld);
      end
      @(posedge clk); #1;
      if (i == 7) req_vld = '0;
    end
  endtask

  task automatic test_random(int ncyc);
    exp_rsp_t      q[$];
    int            g;
    int            a;
    logic [R-1:0]  exp_rdy;
    logic          exp_en = 1'b0, exp_wen = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [W-1:0]  exp_wdata = '0;
    for (int c = 0; c < ncyc + 4; c++) begin
      if (c < ncyc) begin
        req_vld  = R'($urandom);
        req_wen  = R'($urandom);
        req_addr = (R*AW)'($urandom);
        for (int k = 0; k < R; k++) req_wdata[k*W +: W] = W'($urandom);
      end else begin
        req_vld = '0;
      end
      @(negedge clk);
      g = rr_pick(req_vld, ref_ptr);
      exp_rdy = (g >= 0) ? (R'(1) << g) : '0;
      vectors++;
      if (rdy !== exp_rdy) begin
        miscompares++; $display("FAIL rand_grant%0d: rdy=%b want %b", c, rdy, exp_rdy);
      end
      vectors++;
      if ({mem_en, mem_wen, mem_addr, mem_wdata} !== {exp_en, exp_wen, exp_addr, exp_wdata}) begin
        miscompares++;
        $display("FAIL rand_mem%0d: en=%0b wen=%0b addr=%0d wdata=%h want en=%0b wen=%0b addr=%0d wdata=%h",
                 c, mem_en, mem_wen, mem_addr, mem_wdata, exp_en, exp_wen, exp_addr, exp_wdata);
      end
      vectors++;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (rsp_vld !== 1'b1 || rsp_id !== IW'(q[0].id) || rsp_rdata !== q[0].data) begin
          miscompares++;
          $display("FAIL rand_rsp%0d: vld=%0b id=%0d data=%h want vld=1 id=%0d data=%h",
                   c, rsp_vld, rsp_id, rsp_rdata, q[0].id, q[0].data);
        end
        void'(q.pop_front());
      end else if (rsp_vld !== 1'b0) begin
        miscompares++; $display("FAIL rand_idle%0d: rsp_vld=%0b want 0", c, rsp_vld);
      end
      if (g >= 0) begin
        a         = int'(req_addr[g*AW +: AW]);
        exp_en    = 1'b1;
        exp_wen   = req_wen[g];
        exp_addr  = AW'(a);
        exp_wdata = req_wdata[g*W +: W];
        if (req_wen[g]) ref_mem[a] = exp_wdata;
        else q.push_back('{due: cyc + 3, id: g, data: ref_mem[a]});
        ref_ptr = (g + 1) % R;
      end else begin
        exp_en = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] d6, d2;
    int           g;
    d6 = ref_mem[6]; d2 = ref_mem[2];
    req_wen = '0; req_addr[0 +: AW] = AW'(2); req_addr[AW +: AW] = AW'(6);
    req_vld = 2'b10;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b10) begin
      miscompares++; $display("FAIL fl_g0: rdy=%b want 10", rdy);
    end
    @(posedge clk); #1;
    req_vld = 2'b01;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b01) begin
      miscompares++; $display("FAIL fl_g1: rdy=%b want 01", rdy);
    end
    ref_ptr = 1;
    @(posedge clk); #1;
    req_vld = 2'b11; flush_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b00 || busy !== 1'b0) begin
      miscompares++; $display("FAIL fl_block: rdy=%b busy=%0b want rdy=00 busy=0", rdy, busy);
    end
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b00 || busy !== 1'b1) begin
      miscompares++; $display("FAIL fl_drain0: rdy=%b busy=%0b want rdy=00 busy=1", rdy, busy);
    end
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_id !== IW'(1) || rsp_rdata !== d6) begin
      miscompares++;
      $display("FAIL fl_rsp0: vld=%0b id=%0d data=%h want vld=1 id=1 data=%h",
               rsp_vld, rsp_id, rsp_rdata, d6);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b00 || busy !== 1'b1) begin
      miscompares++; $display("FAIL fl_drain1: rdy=%b busy=%0b want rdy=00 busy=1", rdy, busy);
    end
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_id !== IW'(0) || rsp_rdata !== d2) begin
      miscompares++;
      $display("FAIL fl_rsp1: vld=%0b id=%0d data=%h want vld=1 id=0 data=%h",
               rsp_vld, rsp_id, rsp_rdata, d2);
    end
    @(posedge clk); #1;
    req_vld = '0;
    check_sweep("flush_sweep");
    // The pointer survives the flush.
    req_vld = 2'b11;
    @(negedge clk);
    g = rr_pick(req_vld, ref_ptr);
    vectors++;
    if (rdy !== (R'(1) << g)) begin
      miscompares++; $display("FAIL fl_ptr: rdy=%b want %b", rdy, R'(1) << g);
    end
    ref_ptr = (g + 1) % R;
    @(posedge clk); #1;
    req_vld = 2'b01;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b01) begin
      miscompares++; $display("FAIL fl_g2: rdy=%b want 01", rdy);
    end
    ref_ptr = 1;
    @(posedge clk); #1;
    req_vld = '0;
  endtask

  task automatic test_reset_mid_sweep();
    int waited = 0;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk);
    while (!(mem_en === 1'b1 && mem_addr === AW'(4)) && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    vectors++;
    if (waited >= 40) begin
      miscompares++;
      $display("FAIL mid_wait: addr 4 write not seen, addr=%0d want 4", mem_addr);
    end
    #2 rst_n = 1'b0;
    req_vld = 2'b11;
    #1;
    vectors++;
    if (busy !== 1'b1 || rdy !== '0) begin
      miscompares++; $display("FAIL mid_busy: busy=%0b rdy=%b want busy=1 rdy=0", busy, rdy);
    end
    vectors++;
    if ({mem_en, mem_wen, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL mid_mem: en=%0b wen=%0b addr=%0d wdata=%h want all 0",
               mem_en, mem_wen, mem_addr, mem_wdata);
    end
    vectors++;
    if ({rsp_vld, rsp_id, rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL mid_rsp: vld=%0b id=%0d data=%h want all 0", rsp_vld, rsp_id, rsp_rdata);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    req_vld = '0;
    check_sweep("mid_sweep");
    ref_ptr = 0;
    // Pointer is back at 0 after reset.
    req_vld = 2'b11;
    @(negedge clk);
    vectors++;
    if (rdy !== 2'b01) begin
      miscompares++; $display("FAIL mid_ptr: rdy=%b want 01", rdy);
    end
    @(posedge clk); #1;
    req_vld = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_random(300);
    test_flush();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
